// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow-entry record for the ID-stage hazard scheduler.
// Optype values must track the decoder's hazard optype encoding.
package hazard_pkg;

    // Shadow entries store rd zero-extended to this width so the record type is fixed.
    localparam int RA_MAX = 8;

    localparam logic [1:0] OPT_NONE = 2'b00;
    localparam logic [1:0] OPT_ALU  = 2'b01;
    localparam logic [1:0] OPT_LD   = 2'b10;
    localparam logic [1:0] OPT_SD   = 2'b11;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_EX_ALU  = 2'b01;
    localparam logic [1:0] FWD_MEM_ALU = 2'b10;
    localparam logic [1:0] FWD_MEM_LD  = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [RA_MAX-1:0] rd;
        logic [1:0]        optype;
        logic              sdfwd;
    } shadow_entry_t;

endpackage

// File: rtl/hazard_shadow_stage.sv
// One registered shadow entry mirroring a pipeline stage occupant.
// Holds when en is low; clr loads an invalid entry (bubble) on an enabled edge.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  shadow_entry_t d,
    output shadow_entry_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/hazard_sched.sv
// ID-stage hazard scheduler: stall, flush and operand-forward selects from a
// shadow copy of the EX and MEM occupants, plus a saturating load-use stall counter.
module hazard_sched
    import hazard_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1use,
    input  logic             id_rs2use,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [1:0]       id_optype,
    input  logic             id_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_sd_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    shadow_entry_t ex_p1, mem_p2, id_p0;
    logic ex_ld_a, ex_ld_b, sd_exc, stall, bubble, run;
    logic [1:0] sel_a, sel_b;

    function automatic logic hit(shadow_entry_t e, logic [RA_W-1:0] rs);
        return e.valid && (e.optype == OPT_ALU || e.optype == OPT_LD) &&
               e.rd == RA_MAX'(rs) && rs != '0;
    endfunction

    function automatic logic [1:0] fwd_sel(logic use_rs, logic [RA_W-1:0] rs,
                                           shadow_entry_t ex, shadow_entry_t mem);
        if (!use_rs)                                 return FWD_RF;
        if (hit(ex, rs) && ex.optype == OPT_ALU)     return FWD_EX_ALU;
        if (hit(mem, rs) && mem.optype == OPT_ALU)   return FWD_MEM_ALU;
        if (hit(mem, rs) && mem.optype == OPT_LD)    return FWD_MEM_LD;
        return FWD_RF;
    endfunction

    // ---- ID stage: hazard detection against the shadow EX/MEM entries ----
    always_comb begin
        ex_ld_a = id_rs1use && hit(ex_p1, id_rs1) && ex_p1.optype == OPT_LD;
        ex_ld_b = id_rs2use && hit(ex_p1, id_rs2) && ex_p1.optype == OPT_LD;
        // A store whose only dependency on the load is its data waits for it in MEM instead.
        sd_exc  = id_valid && id_optype == OPT_SD && ex_ld_b && !ex_ld_a;
        stall   = id_valid && (ex_ld_a || ex_ld_b) && !sd_exc;
        run     = !mem_busy;
        bubble  = stall && run;
        sel_a   = fwd_sel(id_rs1use, id_rs1, ex_p1, mem_p2);
        sel_b   = sd_exc ? FWD_RF : fwd_sel(id_rs2use, id_rs2, ex_p1, mem_p2);

        id_p0.valid  = id_valid;
        id_p0.rd     = RA_MAX'(id_rd);
        id_p0.optype = id_optype;
        id_p0.sdfwd  = sd_exc;
    end

    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        fwd_a      = FWD_RF;
        fwd_b      = FWD_RF;
        mem_sd_fwd = 1'b0;
        if (!rst) begin
            pc_en      = !stall && run;
            ifid_en    = !stall && run;
            ifid_flush = id_redirect && id_valid && !stall && run;
            idex_flush = bubble;
            fwd_a      = sel_a;
            fwd_b      = sel_b;
            mem_sd_fwd = mem_p2.valid && mem_p2.sdfwd;
        end
    end

    // ---- ID -> EX boundary ----
    hazard_shadow_stage u_ex (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .clr (bubble),
        .d   (id_p0),
        .q   (ex_p1)
    );

    // ---- EX -> MEM boundary ----
    hazard_shadow_stage u_mem (
        .clk (clk),
        .rst (rst),
        .en  (run),
        .clr (1'b0),
        .d   (ex_p1),
        .q   (mem_p2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bubble && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
